// File: rtl/pacman_palette_pkg.sv
// Shared palette indices, ghost bit positions and frightened-mode state type
// for the ghost colour sequencing logic.
package pacman_palette_pkg;

  localparam logic [2:0] BLACK  = 3'd0;
  localparam logic [2:0] YELLOW = 3'd1;
  localparam logic [2:0] RED    = 3'd2;
  localparam logic [2:0] WHITE  = 3'd3;
  localparam logic [2:0] BLUE   = 3'd4;
  localparam logic [2:0] PINK   = 3'd5;
  localparam logic [2:0] CYAN   = 3'd6;
  localparam logic [2:0] ORANGE = 3'd7;

  localparam int BLINKY = 0;
  localparam int PINKY  = 1;
  localparam int INKY   = 2;
  localparam int CLYDE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRIGHT = 2'd1,
    ST_FLASH  = 2'd2
  } fright_state_t;

  // White only on the odd half-period of the flash, blue otherwise.
  function automatic logic [2:0] ghost_color(input logic [2:0] normal,
                                             input logic fright,
                                             input fright_state_t st,
                                             input logic phase);
    if (!fright)                              return normal;
    else if (st == ST_FLASH && phase == 1'b1) return WHITE;
    else                                      return BLUE;
  endfunction

endpackage

// File: rtl/flash_phase_gen.sv
// Blue/white flash phase generator: toggles phase every FLASH_PERIOD ticks.
module flash_phase_gen
  import pacman_palette_pkg::*;
#(
  parameter int FLASH_PERIOD = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick_en,
  output logic phase
);

  localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  logic [PW-1:0] r_phase_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (clear) begin
      r_phase_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (tick_en) begin
      if (r_phase_cnt == PW'(FLASH_PERIOD - 1)) begin
        r_phase_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_phase_cnt <= r_phase_cnt + PW'(1);
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/ghost_fright_ctrl.sv
// Frightened-mode sequencer: drives per-ghost palette indices and exports
// frightened/flashing status plus the remaining frame count.
module ghost_fright_ctrl
  import pacman_palette_pkg::*;
#(
  parameter int FRIGHT_FRAMES = 360,
  parameter int FLASH_FRAMES  = 120,
  parameter int FLASH_PERIOD  = 15,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             energizer_eaten,
  input  logic [3:0]       ghost_eaten,
  output logic [2:0]       blinky_color,
  output logic [2:0]       pinky_color,
  output logic [2:0]       inky_color,
  output logic [2:0]       clyde_color,
  output logic [3:0]       frightened,
  output logic             flashing,
  output logic [CNT_W-1:0] frames_left
);

  fright_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_fright;

  logic             w_tick_en;
  logic             w_active;
  logic [CNT_W-1:0] w_cnt_dec;
  logic [3:0]       w_fright_nxt;
  logic             w_all_clear;
  logic             w_expire;
  logic             w_phase;
  logic             w_phase_clr;
  logic [3:0][2:0]  w_norm;
  logic [3:0][2:0]  w_col;

  assign w_tick_en    = frame_tick & ~pause;
  assign w_active     = (r_state != ST_IDLE);
  assign w_cnt_dec    = r_cnt - CNT_W'(1);
  assign w_fright_nxt = r_fright & ~ghost_eaten;
  assign w_all_clear  = w_active && (w_fright_nxt == 4'b0000);
  assign w_expire     = w_active && w_tick_en && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_fright <= 4'b0000;
    end else if (energizer_eaten) begin
      r_state  <= ST_FRIGHT;
      r_cnt    <= CNT_W'(FRIGHT_FRAMES);
      r_fright <= 4'b1111;
    end else if (w_active) begin
      // An all-clear wins over the timer, even on a tick cycle.
      if (w_all_clear) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_fright <= 4'b0000;
      end else if (w_tick_en) begin
        r_cnt <= w_cnt_dec;
        if (w_expire) begin
          r_state  <= ST_IDLE;
          r_fright <= 4'b0000;
        end else begin
          r_fright <= w_fright_nxt;
          if (r_state == ST_FRIGHT && FLASH_FRAMES != 0 &&
              w_cnt_dec == CNT_W'(FLASH_FRAMES))
            r_state <= ST_FLASH;
        end
      end else begin
        r_fright <= w_fright_nxt;
      end
    end
  end

  // Phase only runs in FLASH; held at zero everywhere else.
  assign w_phase_clr = energizer_eaten | (r_state != ST_FLASH) | w_all_clear | w_expire;

  flash_phase_gen #(.FLASH_PERIOD(FLASH_PERIOD)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_phase_clr),
    .tick_en (w_tick_en),
    .phase   (w_phase)
  );

  assign w_norm = {ORANGE, CYAN, PINK, RED};

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign w_col[g] = ghost_color(w_norm[g], r_fright[g], r_state, w_phase);
  end

  assign blinky_color = w_col[BLINKY];
  assign pinky_color  = w_col[PINKY];
  assign inky_color   = w_col[INKY];
  assign clyde_color  = w_col[CLYDE];
  assign frightened   = r_fright;
  assign flashing     = (r_state == ST_FLASH);
  assign frames_left  = r_cnt;

endmodule

// File: tb/tb_ghost_fright_ctrl.sv
// Directed bench for ghost_fright_ctrl with a short frightened period.
module tb_ghost_fright_ctrl;

  localparam int CNT_W = 10;

  localparam logic [31:0] C_NORM  = {20'd0, 3'd2, 3'd5, 3'd6, 3'd7};
  localparam logic [31:0] C_BLUE  = {20'd0, 3'd4, 3'd4, 3'd4, 3'd4};
  localparam logic [31:0] C_WHITE = {20'd0, 3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [31:0] C_B_EAT = {20'd0, 3'd2, 3'd4, 3'd4, 3'd4};

  logic             gclk = 1'b0;
  logic             grst_n;
  logic             frame_tick;
  logic             pause;
  logic             energizer_eaten;
  logic [3:0]       ghost_eaten;
  logic [2:0]       blinky_color, pinky_color, inky_color, clyde_color;
  logic [3:0]       frightened;
  logic             flashing;
  logic [CNT_W-1:0] frames_left;

  int n_chk = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  ghost_fright_ctrl #(
    .FRIGHT_FRAMES(10), .FLASH_FRAMES(4), .FLASH_PERIOD(2), .CNT_W(CNT_W)
  ) dut (
    .clk             (gclk),
    .rst_n           (grst_n),
    .frame_tick      (frame_tick),
    .pause           (pause),
    .energizer_eaten (energizer_eaten),
    .ghost_eaten     (ghost_eaten),
    .blinky_color    (blinky_color),
    .pinky_color     (pinky_color),
    .inky_color      (inky_color),
    .clyde_color     (clyde_color),
    .frightened      (frightened),
    .flashing        (flashing),
    .frames_left     (frames_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cols();
    return {20'd0, blinky_color, pinky_color, inky_color, clyde_color};
  endfunction

  // Drive one cycle of inputs, clock it, sample #1 after the edge.
  task automatic step(input logic ft, input logic pz, input logic en, input logic [3:0] ge);
    frame_tick = ft; pause = pz; energizer_eaten = en; ghost_eaten = ge;
    @(posedge gclk); #1;
    frame_tick = 1'b0; pause = 1'b0; energizer_eaten = 1'b0; ghost_eaten = 4'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 4'b0);
  endtask

  task automatic do_reset();
    grst_n = 1'b0;
    frame_tick = 1'b0; pause = 1'b0; energizer_eaten = 1'b0; ghost_eaten = 4'b0;
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1;
    @(posedge gclk); #1;
  endtask

  initial begin
    do_reset();
    chk("rst_cols",   cols(), C_NORM);
    chk("rst_fright", 32'(frightened), 32'd0);
    chk("rst_flash",  32'(flashing), 32'd0);
    chk("rst_left",   32'(frames_left), 32'd0);

    // Idle: ticks and ghost_eaten are no-ops
    step(1'b1, 1'b0, 1'b0, 4'b1111);
    chk("idle_left",   32'(frames_left), 32'd0);
    chk("idle_fright", 32'(frightened), 32'd0);

    // Full frightened period
    step(1'b0, 1'b0, 1'b1, 4'b0);
    chk("en_cols",   cols(), C_BLUE);
    chk("en_fright", 32'(frightened), 32'hF);
    chk("en_left",   32'(frames_left), 32'd10);
    ticks(5);
    chk("t5_flash", 32'(flashing), 32'd0);
    chk("t5_left",  32'(frames_left), 32'd5);
    ticks(1);
    chk("t6_flash", 32'(flashing), 32'd1);
    chk("t6_cols",  cols(), C_BLUE);
    chk("t6_left",  32'(frames_left), 32'd4);
    ticks(1);
    chk("t7_cols",  cols(), C_BLUE);
    ticks(1);
    chk("t8_cols",  cols(), C_WHITE);
    ticks(1);
    chk("t9_cols",  cols(), C_WHITE);
    chk("t9_left",  32'(frames_left), 32'd1);
    ticks(1);
    chk("t10_cols",   cols(), C_NORM);
    chk("t10_flash",  32'(flashing), 32'd0);
    chk("t10_fright", 32'(frightened), 32'd0);
    chk("t10_left",   32'(frames_left), 32'd0);
    ticks(2);
    chk("post_left",  32'(frames_left), 32'd0);

    // Individual ghosts eaten; tick in the same cycle still decrements
    step(1'b0, 1'b0, 1'b1, 4'b0);
    ticks(2);
    step(1'b1, 1'b0, 1'b0, 4'b0001);
    chk("ge1_cols",   cols(), C_B_EAT);
    chk("ge1_fright", 32'(frightened), 32'hE);
    chk("ge1_left",   32'(frames_left), 32'd7);
    step(1'b1, 1'b0, 1'b0, 4'b1110);
    chk("ge2_cols",   cols(), C_NORM);
    chk("ge2_fright", 32'(frightened), 32'd0);
    chk("ge2_left",   32'(frames_left), 32'd0);
    chk("ge2_flash",  32'(flashing), 32'd0);

    // Restart from FLASH (white) returns to FRIGHT
    step(1'b0, 1'b0, 1'b1, 4'b0);
    ticks(8);
    chk("rs_white", cols(), C_WHITE);
    step(1'b1, 1'b0, 1'b1, 4'b0);
    chk("rs_left",  32'(frames_left), 32'd10);
    chk("rs_cols",  cols(), C_BLUE);
    chk("rs_flash", 32'(flashing), 32'd0);
    ticks(6);
    chk("rs_reflash", 32'(flashing), 32'd1);
    chk("rs_phase0",  cols(), C_BLUE);

    // Paused ticks are lost; energizer beats simultaneous ghost_eaten
    step(1'b0, 1'b0, 1'b1, 4'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 4'b0);
    chk("pz_left", 32'(frames_left), 32'd10);
    step(1'b1, 1'b0, 1'b1, 4'b1111);
    chk("eg_fright", 32'(frightened), 32'hF);
    chk("eg_left",   32'(frames_left), 32'd10);

    // Asynchronous reset mid-FLASH, between clock edges
    ticks(8);
    chk("ar_pre", 32'(flashing), 32'd1);
    #2 grst_n = 1'b0;
    #1;
    chk("ar_cols",   cols(), C_NORM);
    chk("ar_flash",  32'(flashing), 32'd0);
    chk("ar_fright", 32'(frightened), 32'd0);
    chk("ar_left",   32'(frames_left), 32'd0);
    @(posedge gclk); #1 grst_n = 1'b1;
    @(posedge gclk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
